// File: rtl/lv_pkg.sv
// Shared definitions for the register-access arbiter: FSM state encoding
// and requester slot indices.
package lv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RSP  = 2'd2
  } state_e;

  localparam int REQ_SPI = 0;
  localparam int REQ_OW  = 1;
  localparam int REQ_WDG = 2;
  localparam int NREQ    = 3;

endpackage

// File: rtl/lv_arb_pick.sv
// Combinational winner select: SPI > OW > WDG, with the watchdog scanner
// promoted to the top once it has been starved for AGE_MAX cycles.
module lv_arb_pick
  import lv_pkg::*;
#(
  parameter int AGE_MAX = 15
) (
  input  logic [NREQ-1:0] req,
  input  logic [3:0]      age,
  output logic [NREQ-1:0] win
);

  localparam logic [3:0] AGE_LIM = 4'(AGE_MAX);

  always_comb begin
    win = '0;
    if (req[REQ_WDG] && (age >= AGE_LIM)) begin
      win[REQ_WDG] = 1'b1;
    end else if (req[REQ_SPI]) begin
      win[REQ_SPI] = 1'b1;
    end else if (req[REQ_OW]) begin
      win[REQ_OW] = 1'b1;
    end else if (req[REQ_WDG]) begin
      win[REQ_WDG] = 1'b1;
    end
  end

endmodule

// File: rtl/lv_reg_arb.sv
// Three-way register-file arbiter (SPI, one-wire, CRC watchdog) with one
// access in flight and mode-gated write permission.
// Handshake: a requester holds i_req and its payload until its o_gnt pulse;
// the payload is captured on the IDLE cycle that picks it, and o_rvld for
// that requester follows o_gnt by exactly one cycle.
module lv_reg_arb
  import lv_pkg::*;
#(
  parameter int AW      = 7,
  parameter int DW      = 8,
  parameter int CRC_W   = 8,
  parameter int AGE_MAX = 15
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [2:0]         i_req,
  input  logic [2:0]         i_wr,
  input  logic [3*AW-1:0]    i_addr,
  input  logic [3*DW-1:0]    i_wdata,
  input  logic [3*CRC_W-1:0] i_wcrc,
  input  logic               i_test_mode_status,
  input  logic               i_cfg_mode_status,
  output logic [2:0]         o_gnt,
  output logic [2:0]         o_rvld,
  output logic               o_rsp_err,
  output logic [DW-1:0]      o_rdata,
  output logic [CRC_W-1:0]   o_rcrc,
  output logic               o_wen,
  output logic               o_ren,
  output logic [AW-1:0]      o_addr,
  output logic [DW-1:0]      o_wdata,
  output logic [CRC_W-1:0]   o_wcrc,
  input  logic [DW-1:0]      i_rdata,
  input  logic [CRC_W-1:0]   i_rcrc,
  output logic [1:0]         o_dbg_state
);

  state_e            state;
  logic [NREQ-1:0]   win;
  logic [NREQ-1:0]   win_q;
  logic              wr_q;
  logic [AW-1:0]     addr_q;
  logic [DW-1:0]     wdata_q;
  logic [CRC_W-1:0]  wcrc_q;
  logic              err_q;
  logic [3:0]        age_q;
  logic [DW-1:0]     rdata_q;
  logic [CRC_W-1:0]  rcrc_q;

  logic              sel_wr;
  logic [AW-1:0]     sel_addr;
  logic [DW-1:0]     sel_wdata;
  logic [CRC_W-1:0]  sel_wcrc;
  logic              in_acc;
  logic              in_rsp;
  logic              wr_ok;

  lv_arb_pick #(.AGE_MAX(AGE_MAX)) u_pick (
    .req (i_req),
    .age (age_q),
    .win (win)
  );

  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wcrc  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (win[k]) begin
        sel_wr    = i_wr[k];
        sel_addr  = i_addr[k*AW +: AW];
        sel_wdata = i_wdata[k*DW +: DW];
        sel_wcrc  = i_wcrc[k*CRC_W +: CRC_W];
      end
    end
  end

  assign in_acc = (state == ACC);
  assign in_rsp = (state == RSP);
  // The watchdog scanner only ever reads; its writes are refused in any mode.
  assign wr_ok  = !win_q[REQ_WDG] && (i_test_mode_status || i_cfg_mode_status);

  assign o_gnt       = in_acc ? win_q : '0;
  assign o_rvld      = in_rsp ? win_q : '0;
  assign o_rsp_err   = in_rsp && err_q;
  assign o_wen       = in_acc && wr_q && wr_ok;
  assign o_ren       = in_acc && !wr_q;
  assign o_addr      = in_acc ? addr_q  : '0;
  assign o_wdata     = in_acc ? wdata_q : '0;
  assign o_wcrc      = in_acc ? wcrc_q  : '0;
  assign o_rdata     = rdata_q;
  assign o_rcrc      = rcrc_q;
  assign o_dbg_state = state;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      age_q <= '0;
    end else if (!i_req[REQ_WDG] || (in_acc && win_q[REQ_WDG])) begin
      age_q <= '0;
    end else if (age_q != 4'hF) begin
      age_q <= age_q + 4'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      win_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wcrc_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      rcrc_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|i_req) begin
            win_q   <= win;
            wr_q    <= sel_wr;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            wcrc_q  <= sel_wcrc;
            state   <= ACC;
          end
        end
        ACC: begin
          err_q   <= wr_q && !wr_ok;
          rdata_q <= wr_q ? '0 : i_rdata;
          rcrc_q  <= wr_q ? '0 : i_rcrc;
          state   <= RSP;
        end
        RSP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lv_reg_arb.sv
// Directed bench for lv_reg_arb: drivers push expected grant and response
// tuples; a negedge monitor pops and compares whenever the DUT presents them.
module tb_lv_reg_arb;

  localparam int AW = 7;
  localparam int DW = 8;
  localparam int CW = 8;

  logic            i_clk = 1'b0;
  logic            i_rst_n;
  logic [2:0]      i_req, i_wr;
  logic [3*AW-1:0] i_addr;
  logic [3*DW-1:0] i_wdata;
  logic [3*CW-1:0] i_wcrc;
  logic            i_test_mode_status, i_cfg_mode_status;
  logic [2:0]      o_gnt, o_rvld;
  logic            o_rsp_err, o_wen, o_ren;
  logic [DW-1:0]   o_rdata, o_wdata, i_rdata;
  logic [CW-1:0]   o_rcrc, o_wcrc, i_rcrc;
  logic [AW-1:0]   o_addr;
  logic [1:0]      o_dbg_state;

  logic [27:0] gnt_q[$];
  logic [19:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  lv_reg_arb #(.AW(AW), .DW(DW), .CRC_W(CW), .AGE_MAX(15)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_wr(i_wr),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_wcrc(i_wcrc),
    .i_test_mode_status(i_test_mode_status), .i_cfg_mode_status(i_cfg_mode_status),
    .o_gnt(o_gnt), .o_rvld(o_rvld), .o_rsp_err(o_rsp_err), .o_rdata(o_rdata),
    .o_rcrc(o_rcrc), .o_wen(o_wen), .o_ren(o_ren), .o_addr(o_addr),
    .o_wdata(o_wdata), .o_wcrc(o_wcrc), .i_rdata(i_rdata), .i_rcrc(i_rcrc),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  // register-file model: unwritten locations read addr^B7 / {addr,0}^3C
  logic [7:0] mem_d[128];
  logic [7:0] mem_c[128];
  logic       written[128];
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 128; i++) written[i] <= 1'b0;
    end else if (o_wen) begin
      mem_d[o_addr]   <= o_wdata;
      mem_c[o_addr]   <= o_wcrc;
      written[o_addr] <= 1'b1;
    end
  end
  assign i_rdata = written[o_addr] ? mem_d[o_addr] : ({1'b0, o_addr} ^ 8'hB7);
  assign i_rcrc  = written[o_addr] ? mem_c[o_addr] : ({o_addr, 1'b0} ^ 8'h3C);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [27:0] g(input logic [2:0] who, input logic wen, input logic ren,
                                    input logic [6:0] a, input logic [7:0] wd, input logic [7:0] wc);
    return {who, wen, ren, a, wd, wc};
  endfunction

  function automatic logic [19:0] r(input logic [2:0] who, input logic err,
                                    input logic [7:0] rd, input logic [7:0] rc);
    return {who, err, rd, rc};
  endfunction

  // driver: raise request k, hold until granted, then drop and scramble payload
  task automatic drive(input int k, input logic wr, input logic [6:0] a, input logic [7:0] wd,
                       input logic [7:0] wc, input int exp_wait);
    int c;
    bit got;
    @(negedge i_clk);
    i_wr[k] = wr;
    i_addr[k*AW +: AW]  = a;
    i_wdata[k*DW +: DW] = wd;
    i_wcrc[k*CW +: CW]  = wc;
    i_req[k] = 1'b1;
    got = 0;
    for (c = 1; c <= 100; c++) begin
      @(negedge i_clk);
      if (o_gnt[k]) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL gnt_timeout req%0d: got no grant expected grant within 100 cycles", k);
    end else if (exp_wait > 0) begin
      check("gnt_wait", 64'(c), 64'(exp_wait));
    end
    i_req[k] = 1'b0;
    i_addr[k*AW +: AW]  = ~a;
    i_wdata[k*DW +: DW] = ~wd;
    i_wcrc[k*CW +: CW]  = ~wc;
  endtask

  task automatic settle();
    repeat (3) @(negedge i_clk);
  endtask

  // scoreboard monitor
  initial begin
    int ncyc = 0;
    int last_gnt = 0;
    bit have_gnt = 0;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        have_gnt = 0;
      end else begin
        ncyc++;
        if (o_wen || o_ren) check("wen_ren_excl", 64'(o_wen & o_ren), 64'd0);
        if (o_gnt != 3'b000) begin
          check("gnt_onehot", 64'($countones(o_gnt)), 64'd1);
          if (have_gnt) check("gnt_spacing_ge3", 64'(ncyc - last_gnt >= 3), 64'd1);
          if (gnt_q.size() == 0) check("gnt_extra", 64'({o_gnt, o_wen, o_ren, o_addr, o_wdata, o_wcrc}), 64'd0);
          else check("gnt", 64'({o_gnt, o_wen, o_ren, o_addr, o_wdata, o_wcrc}), 64'(gnt_q.pop_front()));
          last_gnt = ncyc;
          have_gnt = 1;
        end
        if (o_rvld != 3'b000) begin
          check("rvld_onehot", 64'($countones(o_rvld)), 64'd1);
          check("rvld_latency", 64'(ncyc - last_gnt), 64'd1);
          if (exp_q.size() == 0) check("rsp_extra", 64'({o_rvld, o_rsp_err, o_rdata, o_rcrc}), 64'd0);
          else check("rsp", 64'({o_rvld, o_rsp_err, o_rdata, o_rcrc}), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    bit got;
    i_rst_n = 1'b0;
    i_req = '0; i_wr = '0; i_addr = '0; i_wdata = '0; i_wcrc = '0;
    i_test_mode_status = 1'b0; i_cfg_mode_status = 1'b0;
    repeat (3) @(negedge i_clk);
    check("reset_outputs", 64'({o_gnt, o_rvld, o_rsp_err, o_wen, o_ren, o_addr, o_wdata,
                                o_wcrc, o_rdata, o_rcrc, o_dbg_state}), 64'd0);
    i_rst_n = 1'b1;
    settle();

    // SPI read at 0x12 returns A5 / 18
    gnt_q.push_back(g(3'b001, 0, 1, 7'h12, 8'h00, 8'h00));
    exp_q.push_back(r(3'b001, 0, 8'hA5, 8'h18));
    drive(0, 0, 7'h12, 8'h00, 8'h00, 1);
    settle();

    // SPI and OW together: SPI first, OW three cycles later
    gnt_q.push_back(g(3'b001, 0, 1, 7'h20, 8'h00, 8'h00));
    gnt_q.push_back(g(3'b010, 0, 1, 7'h21, 8'h00, 8'h00));
    exp_q.push_back(r(3'b001, 0, 8'h97, 8'h7C));
    exp_q.push_back(r(3'b010, 0, 8'h96, 8'h7E));
    fork
      drive(0, 0, 7'h20, 8'h00, 8'h00, 1);
      drive(1, 0, 7'h21, 8'h00, 8'h00, 4);
    join
    settle();

    // OW write with no mode: rejected, memory untouched
    gnt_q.push_back(g(3'b010, 0, 0, 7'h33, 8'h77, 8'h11));
    exp_q.push_back(r(3'b010, 1, 8'h00, 8'h00));
    drive(1, 1, 7'h33, 8'h77, 8'h11, 1);
    settle();
    gnt_q.push_back(g(3'b001, 0, 1, 7'h33, 8'h00, 8'h00));
    exp_q.push_back(r(3'b001, 0, 8'h84, 8'h5A));
    drive(0, 0, 7'h33, 8'h00, 8'h00, 1);
    settle();

    // same OW write in cfg mode: accepted and visible on read-back
    i_cfg_mode_status = 1'b1;
    gnt_q.push_back(g(3'b010, 1, 0, 7'h33, 8'h77, 8'h11));
    exp_q.push_back(r(3'b010, 0, 8'h00, 8'h00));
    drive(1, 1, 7'h33, 8'h77, 8'h11, 1);
    settle();
    i_cfg_mode_status = 1'b0;
    gnt_q.push_back(g(3'b001, 0, 1, 7'h33, 8'h00, 8'h00));
    exp_q.push_back(r(3'b001, 0, 8'h77, 8'h11));
    drive(0, 0, 7'h33, 8'h00, 8'h00, 1);
    settle();

    // test mode: WDG write still refused, SPI write accepted
    i_test_mode_status = 1'b1;
    gnt_q.push_back(g(3'b100, 0, 0, 7'h50, 8'hEE, 8'hDD));
    exp_q.push_back(r(3'b100, 1, 8'h00, 8'h00));
    drive(2, 1, 7'h50, 8'hEE, 8'hDD, 1);
    settle();
    gnt_q.push_back(g(3'b001, 1, 0, 7'h51, 8'h5A, 8'hC3));
    exp_q.push_back(r(3'b001, 0, 8'h00, 8'h00));
    drive(0, 1, 7'h51, 8'h5A, 8'hC3, 1);
    settle();
    i_test_mode_status = 1'b0;

    // aging: SPI held, WDG pending -> five SPI grants then WDG at age 15
    for (int i = 0; i < 5; i++) begin
      gnt_q.push_back(g(3'b001, 0, 1, 7'h40, 8'h00, 8'h00));
      exp_q.push_back(r(3'b001, 0, 8'hF7, 8'hBC));
    end
    gnt_q.push_back(g(3'b100, 0, 1, 7'h41, 8'h00, 8'h00));
    exp_q.push_back(r(3'b100, 0, 8'hF6, 8'hBE));
    @(negedge i_clk);
    i_wr = 3'b000;
    i_addr[0*AW +: AW] = 7'h40; i_wdata[0*DW +: DW] = 8'h00; i_wcrc[0*CW +: CW] = 8'h00;
    i_addr[2*AW +: AW] = 7'h41; i_wdata[2*DW +: DW] = 8'h00; i_wcrc[2*CW +: CW] = 8'h00;
    i_req = 3'b101;
    got = 0;
    for (c = 1; c <= 100; c++) begin
      @(negedge i_clk);
      if (o_gnt[2]) begin
        got = 1;
        break;
      end
    end
    check("wdg_aged_wait", 64'(got ? c : 0), 64'd16);
    i_req = 3'b000;
    settle();

    // reset while in ACC: outputs clear at once, no response follows
    gnt_q.push_back(g(3'b001, 0, 1, 7'h12, 8'h00, 8'h00));
    drive(0, 0, 7'h12, 8'h00, 8'h00, 1);
    #2 i_rst_n = 1'b0;
    #1 check("abort_outputs", 64'({o_gnt, o_rvld, o_rsp_err, o_wen, o_ren, o_addr, o_wdata,
                                   o_wcrc, o_rdata, o_rcrc, o_dbg_state}), 64'd0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (5) @(negedge i_clk);
    gnt_q.push_back(g(3'b001, 0, 1, 7'h20, 8'h00, 8'h00));
    exp_q.push_back(r(3'b001, 0, 8'h97, 8'h7C));
    drive(0, 0, 7'h20, 8'h00, 8'h00, 1);

    for (int i = 0; i < 20 && (gnt_q.size() != 0 || exp_q.size() != 0); i++) @(negedge i_clk);
    check("gnt_q_drained", 64'(gnt_q.size()), 64'd0);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lv_reg_arb.md
LV_REG_ARB -- requirements
Module: lv_reg_arb

Interface
REQ-001 Parameter AW, default 7, register address width.
REQ-002 Parameter DW, default 8, register data width.
REQ-003 Parameter CRC_W, default 8, per-register CRC width.
REQ-004 Parameter AGE_MAX, default 15, wait cycles before the watchdog requester is promoted.
REQ-005 i_clk input 1: clock.
REQ-006 i_rst_n input 1: reset, asynchronous, active-low.
REQ-007 i_req input 3: access request; bit0 SPI, bit1 one-wire (OW), bit2 CRC watchdog scanner (WDG).
REQ-008 i_wr input 3: per-requester, 1 = write, 0 = read.
REQ-009 i_addr input 3*AW: per-requester address, requester k at bits [k*AW +: AW].
REQ-010 i_wdata input 3*DW: per-requester write data.
REQ-011 i_wcrc input 3*CRC_W: per-requester write CRC.
REQ-012 i_test_mode_status input 1: test mode active.
REQ-013 i_cfg_mode_status input 1: cfg mode active.
REQ-014 o_gnt output 3: one-hot grant pulse, 1 cycle.
REQ-015 o_rvld output 3: one-hot response-valid pulse, 1 cycle.
REQ-016 o_rsp_err output 1: write rejected; qualified by o_rvld.
REQ-017 o_rdata output DW, o_rcrc output CRC_W: response data, shared by all requesters.
REQ-018 o_wen, o_ren output 1 each: register-file strobes.
REQ-019 o_addr output AW, o_wdata output DW, o_wcrc output CRC_W: register-file access bus.
REQ-020 i_rdata input DW, i_rcrc input CRC_W: register-file read return, combinational, same cycle as o_ren.

Function
REQ-021 FSM states: IDLE, ACC, RSP; exactly one access in flight.
REQ-022 IDLE: if any i_req is high, pick a winner, capture its wr/addr/wdata/wcrc, and go to ACC; otherwise stay in IDLE.
REQ-023 Priority is SPI > OW > WDG, except that when age_cnt >= AGE_MAX the order is WDG > SPI > OW.
REQ-024 age_cnt: 4-bit counter; +1 per cycle while i_req[2] is high and WDG is not granted; cleared on a WDG grant or when i_req[2] is low; saturates at 15.
REQ-025 ACC: o_gnt[winner] = 1 and o_addr/o_wdata/o_wcrc carry the captured payload for one cycle; next state is RSP.
REQ-026 ACC read: o_ren = 1 in all modes; i_rdata and i_rcrc are registered into o_rdata and o_rcrc.
REQ-027 ACC write: o_wen = 1 only if the requester is SPI or OW and (i_test_mode_status | i_cfg_mode_status) = 1; otherwise o_wen = 0 and an err flag is registered.
REQ-028 WDG writes are always rejected.
REQ-029 RSP: o_rvld[winner] = 1 and o_rsp_err = err flag; o_rdata and o_rcrc = 0 for writes; next state is IDLE.
REQ-030 Latency: request sampled in IDLE at cycle N, o_gnt at N+1, o_rvld at N+2; minimum of 3 cycles between grants.
REQ-031 Requesters hold req and payload until o_gnt; dropping req before grant withdraws the request with no side effect.
REQ-032 Payload changes after capture are ignored.
REQ-033 o_wen and o_ren are never high together; o_gnt and o_rvld are each one-hot or zero.
REQ-034 Simultaneous requests: only the winner is granted; losers keep waiting, with no loss or reordering within a requester.

Reset
REQ-035 Asynchronous assertion forces IDLE; all outputs 0; age_cnt 0; captured payload 0; err flag 0.
REQ-036 Reset during ACC or RSP aborts the access; no o_rvld follows; the first grant comes 1 cycle after a req is sampled post-release.

Structure
REQ-037 Shared package lv_pkg holds the state enum (IDLE/ACC/RSP) and the requester index constants (REQ_SPI=0, REQ_OW=1, REQ_WDG=2).
REQ-038 Sub-module lv_arb_pick: combinational priority select with aging override, output is a one-hot winner.
REQ-039 Target size: 150-250 RTL lines.

Verification
REQ-040 SPI read addr 0x12 with i_rdata = 0xA5 -> o_ren and o_gnt[0] at N+1; o_rvld[0], o_rdata = 0xA5 and o_rcrc at N+2.
REQ-041 SPI and OW request in the same cycle -> SPI granted first; OW granted 3 cycles later.
REQ-042 SPI held continuously with WDG pending -> WDG granted once age_cnt reaches 15, ahead of SPI.
REQ-043 OW write with both mode bits 0 -> o_wen stays 0; o_rvld[1] with o_rsp_err = 1.
REQ-044 Same OW write with cfg mode = 1 -> o_wen = 1; o_rsp_err = 0.
REQ-045 i_rst_n pulsed low during ACC -> all outputs 0 immediately; no o_rvld afterward.
